// File: rtl/ternary_mac_array_pkg.sv
// Shared types and helpers for the ternary MAC tile: weight codes, output
// FSM states and the readout post-processing (shift, ReLU, saturate).
package ternary_pkg;

  localparam logic [1:0] W_ZERO = 2'b00;
  localparam logic [1:0] W_POS  = 2'b01;
  // Any code with bit 1 set decodes to -1.

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  // Arithmetic right shift, optional clamp of negatives to zero, then
  // saturation to a signed out_w-bit range. Operands fit in 32 bits.
  function automatic int post_proc(input int x, input int sh,
                                   input logic relu, input int out_w);
    int y;
    int hi;
    int lo;
    y  = x >>> sh;
    if (relu && (y < 0)) y = 0;
    hi = (1 << (out_w - 1)) - 1;
    lo = -(1 << (out_w - 1));
    if (y > hi)      y = hi;
    else if (y < lo) y = lo;
    return y;
  endfunction

endpackage

// File: rtl/ternary_mac_array_if.sv
// Input stream, readout control and output stream of the ternary MAC tile.
interface ternary_mac_array_if #(
  parameter int ROWS    = 4,
  parameter int COLS    = 2,
  parameter int IN_W    = 8,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 4
);
  logic                 in_valid;
  logic [2*ROWS-1:0]    weights;
  logic [COLS*IN_W-1:0] acts;
  logic                 readout_req;
  logic [SHIFT_W-1:0]   shift_amt;
  logic                 relu_en;
  logic                 readout_ack;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_W-1:0]     out_data;
  logic                 out_last;
  logic                 busy;

  modport master (
    output in_valid, weights, acts, readout_req, shift_amt, relu_en, out_ready,
    input  readout_ack, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  in_valid, weights, acts, readout_req, shift_amt, relu_en, out_ready,
    output readout_ack, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/ternary_mac_cell.sv
// One ternary-weight accumulator. o_next is the value the accumulator would
// take this cycle, so the tile can snapshot it while clearing.
module ternary_mac_cell
  import ternary_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int ACC_W = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [1:0]       i_w,
  input  logic [IN_W-1:0]  i_act,
  output logic [ACC_W-1:0] o_next
);
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_act;
  logic [ACC_W-1:0] w_prod;

  assign w_act = {{(ACC_W-IN_W){i_act[IN_W-1]}}, i_act};

  // Ternary decode: zero, pass or negate the sign-extended activation.
  always_comb begin
    w_prod = '0;
    if (i_w == W_POS)  w_prod = w_act;
    else if (i_w[1])   w_prod = -w_act;
  end

  assign o_next = i_en ? (r_acc + w_prod) : r_acc;

  // Accumulate (wrapping) or clear when the tile is snapshotted.
  always_ff @(posedge clk) begin
    if (reset || i_clr) r_acc <= '0;
    else                r_acc <= o_next;
  end
endmodule

// File: rtl/ternary_mac_array.sv
// ROWS x COLS ternary MAC tile with snapshot-and-clear readout and a
// valid/ready result stream (row-major order) with shift/ReLU/saturation.
module ternary_mac_array
  import ternary_pkg::*;
#(
  parameter int ROWS    = 4,
  parameter int COLS    = 2,
  parameter int IN_W    = 8,
  parameter int ACC_W   = 17,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 4
) (
  input logic clk,
  input logic reset,
  ternary_mac_array_if.slave bus
);
  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  state_t                    r_state, w_state_nxt;
  logic [IDX_W-1:0]          r_idx, w_idx_nxt;
  logic [N-1:0][ACC_W-1:0]   w_next;
  logic [N-1:0][ACC_W-1:0]   r_buf;
  logic [SHIFT_W-1:0]        r_shift;
  logic                      r_relu;
  logic                      w_busy, w_accept, w_last;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      ternary_mac_cell #(.IN_W(IN_W), .ACC_W(ACC_W)) u_cell (
        .clk    (clk),
        .reset  (reset),
        .i_en   (bus.in_valid),
        .i_clr  (w_accept),
        .i_w    (bus.weights[2*r +: 2]),
        .i_act  (bus.acts[c*IN_W +: IN_W]),
        .o_next (w_next[r*COLS+c])
      );
    end
  end

  assign w_busy   = (r_state == S_STREAM);
  assign w_accept = bus.readout_req & ~w_busy & ~reset;
  assign w_last   = (r_idx == IDX_W'(N-1));

  // Snapshot the post-update accumulators and the readout settings.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf   <= '0;
      r_shift <= '0;
      r_relu  <= 1'b0;
    end else if (w_accept) begin
      r_buf   <= w_next;
      r_shift <= bus.shift_amt;
      r_relu  <= bus.relu_en;
    end
  end

  // Output FSM state and stream index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next state: start on accept, advance the index on each transfer.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: if (w_accept) begin
        w_state_nxt = S_STREAM;
        w_idx_nxt   = '0;
      end
      S_STREAM: if (bus.out_ready) begin
        if (w_last) w_state_nxt = S_IDLE;
        else        w_idx_nxt   = r_idx + 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.readout_ack = w_accept;
  assign bus.out_valid   = w_busy;
  assign bus.busy        = w_busy;
  assign bus.out_last    = w_busy & w_last;
  assign bus.out_data    = OUT_W'(post_proc(int'($signed(r_buf[r_idx])),
                                            int'(r_shift), r_relu, OUT_W));
endmodule

// File: tb/tb_ternary_mac_array.sv
// Bench for ternary_mac_array: spec test-plan table, hand-written corner
// sequences and a randomized run against an arithmetic tile model.
module tb_ternary_mac_array;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ternary_mac_array_if #(.ROWS(4), .COLS(2), .IN_W(8), .OUT_W(8), .SHIFT_W(4)) bus ();

  ternary_mac_array #(.ROWS(4), .COLS(2), .IN_W(8), .ACC_W(17), .OUT_W(8), .SHIFT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int macc[8];
  int expq[$];
  int got[$];

  typedef struct {
    logic [7:0] w;
    int a0, a1, n, sh;
    bit rl;
    int e0, e1;
  } vec_t;
  vec_t tv[4];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  function automatic int wrap17(input int v);
    int m;
    m = v & 32'h1FFFF;
    if (m >= 65536) m -= 131072;
    return m;
  endfunction

  function automatic int post(input int x, input int sh, input bit rl);
    int y;
    y = x >>> sh;
    if (rl && y < 0) y = 0;
    if (y > 127)  y = 127;
    if (y < -128) y = -128;
    return y;
  endfunction

  // One clock: drive at negedge, check at +1, then update the model.
  task automatic cyc(input bit v, input logic [7:0] w, input logic [15:0] a,
                     input bit req, input int sh, input bit rl, input bit rdy);
    int nxt[8];
    bit eack;
    int wt, av;
    logic [1:0] code;
    @(negedge clk);
    bus.in_valid = v; bus.weights = w; bus.acts = a; bus.readout_req = req;
    bus.shift_amt = sh[3:0]; bus.relu_en = rl; bus.out_ready = rdy;
    #1;
    eack = req && (expq.size() == 0);
    chk("ack",   int'(bus.readout_ack), int'(eack));
    chk("valid", int'(bus.out_valid), int'(expq.size() != 0));
    chk("busy",  int'(bus.busy), int'(expq.size() != 0));
    if (expq.size() != 0) begin
      chk("data", int'($signed(bus.out_data)), expq[0]);
      chk("last", int'(bus.out_last), int'(expq.size() == 1));
      if (rdy) begin
        got.push_back(int'($signed(bus.out_data)));
        void'(expq.pop_front());
      end
    end
    for (int r = 0; r < 4; r++) begin
      code = w[2*r +: 2];
      wt = (code == 2'd0) ? 0 : (code == 2'd1) ? 1 : -1;
      for (int c = 0; c < 2; c++) begin
        av = int'($signed(a[8*c +: 8]));
        nxt[r*2+c] = v ? wrap17(macc[r*2+c] + wt * av) : macc[r*2+c];
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (eack) begin
        expq.push_back(post(nxt[i], sh, rl));
        macc[i] = 0;
      end else begin
        macc[i] = nxt[i];
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid = 0; bus.readout_req = 0; bus.out_ready = 0;
    @(negedge clk);
    reset = 1'b0;
    foreach (macc[i]) macc[i] = 0;
    expq.delete();
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 100) begin
      cyc(0, 8'h00, 16'h0000, 0, 0, 0, 1);
      n++;
    end
    chk("drain_done", expq.size(), 0);
  endtask

  task automatic readout(input int sh, input bit rl);
    got.delete();
    cyc(0, 8'h00, 16'h0000, 1, sh, rl, 1);
    drain();
    chk("ntransfers", got.size(), 8);
  endtask

  task automatic chk_all(input string nm, input int v);
    foreach (got[k]) chk($sformatf("%s_%0d", nm, k), got[k], v);
  endtask

  initial begin
    logic [7:0] b0, b1;
    int k;
    reset = 1'b1;
    bus.in_valid = 0; bus.weights = '0; bus.acts = '0; bus.readout_req = 0;
    bus.shift_amt = '0; bus.relu_en = 0; bus.out_ready = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    foreach (macc[i]) macc[i] = 0;
    cyc(0, 8'h00, 16'h0000, 0, 0, 0, 1);
    chk("rst_data", int'(bus.out_data), 0);
    chk("rst_last", int'(bus.out_last), 0);

    // Test-plan table: accumulate n cycles, read out, compare constants.
    tv[0] = '{w:8'h55, a0:-2,  a1:3,   n:3, sh:0, rl:0, e0:-6,   e1:9};
    tv[1] = '{w:8'hAA, a0:100, a1:100, n:3, sh:0, rl:0, e0:-128, e1:-128};
    tv[2] = '{w:8'hAA, a0:100, a1:100, n:3, sh:2, rl:0, e0:-75,  e1:-75};
    tv[3] = '{w:8'hAA, a0:100, a1:100, n:3, sh:0, rl:1, e0:0,    e1:0};
    for (int t = 0; t < 4; t++) begin
      b0 = tv[t].a0[7:0];
      b1 = tv[t].a1[7:0];
      repeat (tv[t].n) cyc(1, tv[t].w, {b1, b0}, 0, 0, 0, 1);
      readout(tv[t].sh, tv[t].rl);
      foreach (got[j])
        chk($sformatf("tv%0d_out%0d", t, j), got[j], (j % 2) ? tv[t].e1 : tv[t].e0);
    end

    // Readout in the same cycle as an input: that product is included.
    cyc(1, 8'h55, {8'd5, 8'd5}, 0, 0, 0, 1);
    got.delete();
    cyc(1, 8'h55, {8'd5, 8'd5}, 1, 0, 0, 1);
    drain();
    chk("c3_n", got.size(), 8);
    chk_all("c3_snap", 10);
    readout(0, 0);
    chk_all("c3_zero", 0);

    // Stalls: ready pattern 1,0,0 repeating.
    cyc(1, 8'h55, {8'd1, 8'd2}, 0, 0, 0, 1);
    got.delete();
    cyc(0, 8'h00, 16'h0000, 1, 0, 0, 1);
    k = 0;
    while (expq.size() != 0 && k < 100) begin
      cyc(0, 8'h00, 16'h0000, 0, 0, 0, (k % 3) == 0);
      k++;
    end
    chk("c4_n", got.size(), 8);
    foreach (got[j]) chk($sformatf("c4_out%0d", j), got[j], (j % 2) ? 1 : 2);

    // Request while busy is ignored; the input still accumulates.
    cyc(1, 8'h55, {8'd1, 8'd1}, 0, 0, 0, 1);
    got.delete();
    cyc(0, 8'h00, 16'h0000, 1, 0, 0, 1);
    cyc(0, 8'h00, 16'h0000, 0, 0, 0, 1);
    cyc(0, 8'h00, 16'h0000, 0, 0, 0, 1);
    cyc(1, 8'h55, {8'd7, 8'd7}, 1, 3, 1, 1);
    chk("c5_noack", int'(bus.readout_ack), 0);
    drain();
    chk("c5_n", got.size(), 8);
    chk_all("c5_tile", 1);
    readout(0, 0);
    chk_all("c5_sevens", 7);

    // Reset at the third output discards the tile.
    cyc(1, 8'h55, {8'd2, 8'd2}, 0, 0, 0, 1);
    cyc(0, 8'h00, 16'h0000, 1, 0, 0, 1);
    cyc(0, 8'h00, 16'h0000, 0, 0, 0, 1);
    cyc(0, 8'h00, 16'h0000, 0, 0, 0, 1);
    do_reset();
    cyc(0, 8'h00, 16'h0000, 0, 0, 0, 1);
    chk("c6_valid", int'(bus.out_valid), 0);
    chk("c6_busy",  int'(bus.busy), 0);
    chk("c6_data",  int'(bus.out_data), 0);
    readout(0, 0);
    chk_all("c6_zero", 0);

    // Randomized traffic, including back-to-back requests and resets.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else cyc(1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom),
               $urandom_range(0, 5) == 0, int'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ternary_mac_array.md
Name: ternary_mac_array

Overview:
- Parametrised successor to the 4x1 ternary (1.58-bit) multiply-accumulate array.
- Accumulates a ROWS x COLS tile of ternary-weight x signed-activation products.
- On request, snapshots the tile into an output buffer and clears the accumulators so accumulation continues without a gap.
- Streams results one per cycle through a valid/ready handshake, with arithmetic shift, optional ReLU and saturation to OUT_W. Sits between the pin-level ternary unpacker and the chip output mux.

Parameters:
- ROWS, 4, number of weight lanes (tile rows).
- COLS, 2, number of activation lanes (tile columns).
- IN_W, 8, signed activation width.
- ACC_W, 17, signed accumulator width; must be > IN_W.
- OUT_W, 8, signed result width after post-processing.
- SHIFT_W, 4, width of the shift-amount input.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  weights/acts valid this cycle; accumulate
- weights  in  2*ROWS  ternary weight per row; pair [2r+1:2r]
- acts  in  COLS*IN_W  signed activation per column; slice c = [c*IN_W +: IN_W]
- readout_req  in  1  request snapshot+clear+stream
- shift_amt  in  SHIFT_W  arithmetic right shift applied on readout
- relu_en  in  1  clamp negatives to 0 on readout
- readout_ack  out  1  1-cycle pulse: request accepted
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- out_data  out  OUT_W  post-processed result
- out_last  out  1  marks final element of a tile
- busy  out  1  output buffer draining

Behaviour:
- Weight decode per row: 00 -> 0, 01 -> +1, 10 or 11 -> -1.
- Accumulators acc[r][c] are ACC_W signed.
  - When in_valid, next = acc + w_r*sext(act_c).
  - Otherwise acc holds. Overflow wraps modulo 2^ACC_W.
- Readout is accepted when readout_req=1 and busy=0. In that cycle:
  - readout_ack=1.
  - buf[r][c] <= next-value of acc, including the current in_valid product.
  - acc <= 0.
  - shift_amt and relu_en are latched for the whole tile.
- readout_req while busy=1: ignored. No ack; accumulators unaffected.
- Output FSM states:
  - IDLE: busy=0, out_valid=0. On accept -> STREAM, idx=0.
  - STREAM: busy=1, out_valid=1, out_data=post(buf[idx]). Index order is row-major, idx = r*COLS+c.
  - A transfer occurs when out_valid & out_ready.
  - On transfer: if idx = ROWS*COLS-1, -> IDLE; else idx+1.
  - out_last=1 when idx = ROWS*COLS-1 and out_valid=1.
  - With out_ready=0, out_data, out_last and idx hold stable.
- Latency: first out_valid on the cycle after readout_ack. A full tile takes ROWS*COLS cycles at out_ready=1.
- Back-to-back readout: a request in the same cycle as the final transfer is not accepted; busy is still 1.
- post(x), applied in order:
  - y = x >>> shift_amt (sign-preserving).
  - If relu_en and y<0, y = 0.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Reset, including mid-stream:
  - acc, buf and idx cleared to 0; FSM -> IDLE.
  - out_valid, readout_ack, out_last and busy = 0; out_data = 0.
  - Any partial tile is discarded.
- Accumulation runs independently of the FSM state. in_valid during STREAM is always accumulated.

Decomposition:
- Package ternary_pkg holds:
  - Weight-code constants W_ZERO=2'b00, W_POS=2'b01; bit1 set = negative.
  - FSM state enum {S_IDLE, S_STREAM}.
  - A function computing the saturating shift/ReLU.
- Sub-module ternary_mac_cell: one accumulator with decode, add/sub/hold, clear and snapshot-next output. Instantiated ROWS*COLS times via generate.

Test Plan:
- Setup for all cases: ROWS=4, COLS=2. Every case ends with a readout.
- Case 1: weights=8'h55, acts {c1=3, c0=-2}, in_valid for 3 cycles; readout shift 0, relu 0. Expect 8 outputs: -6, 9, -6, 9, -6, 9, -6, 9. out_last only on the 8th.
- Case 2: weights=8'hAA (-1), acts both 100, 3 cycles, so acc = -300.
  - shift 0: every output is -128 (saturated).
  - Repeat with shift 2: -75.
  - Repeat with relu_en=1: 0.
- Case 3: readout_req in the same cycle as in_valid (weights 8'h55, acts 5,5), after 1 prior identical cycle. Expect snapshot 10 and accumulators 0. A following readout with no input yields all 0.
- Case 4: out_ready toggles 1,0,0,1,... during the stream. Expect out_data held during stall cycles, exactly 8 transfers, no duplicates or skips.
- Case 5: readout_req asserted mid-stream while in_valid accumulates 7. Expect no ack and the current tile unchanged. The next accepted readout returns 7s.
- Case 6: reset asserted at the 3rd output. Next cycle: out_valid=0, busy=0. A subsequent readout with no input returns all 0.
